// File: rtl/synth_pkg.sv
// Shared constants and types for the note oscillators feeding sequential_divider.
// The base period table is the octave-4 period (in 10 MHz clocks) of each semitone.
package synth_pkg;

  localparam int CNT_W      = 16;
  localparam int SAMPLE_CYC = 256;
  localparam int OCT_W      = 2;
  localparam int NUM_NOTES  = 12;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_REST = 4'd0;

  // C4..B4, index 0 corresponds to note_sel = 1
  localparam logic [CNT_W-1:0] BASE_PERIOD [NUM_NOTES] = '{
    16'd38222, 16'd36078, 16'd34053, 16'd32141,
    16'd30337, 16'd28635, 16'd27027, 16'd25510,
    16'd24079, 16'd22727, 16'd21452, 16'd20248
  };

  function automatic logic is_active(input note_t n);
    return (n >= 4'd1) && (n <= 4'd12);
  endfunction

endpackage

// File: rtl/oscillator_counter_if.sv
// Note-select inputs and the operand pair handed to the downstream divider.
// Handshake: the operand pair (divider, dividend, en) is valid and stable from one
// sample_strobe pulse to the next; there is no ready, the consumer must accept every strobe.
interface oscillator_counter_if #(
  parameter int CNT_W = synth_pkg::CNT_W,
  parameter int OCT_W = synth_pkg::OCT_W
);

  logic [3:0]       note_sel;
  logic [OCT_W-1:0] octave;
  logic [CNT_W-1:0] divider;
  logic [CNT_W-1:0] dividend;
  logic             en;
  logic             sample_strobe;

  modport master (
    input  note_sel,
    input  octave,
    output divider,
    output dividend,
    output en,
    output sample_strobe
  );

  modport slave (
    output note_sel,
    output octave,
    input  divider,
    input  dividend,
    input  en,
    input  sample_strobe
  );

endinterface

// File: rtl/note_period_rom.sv
// Combinational lookup from note number to its octave-4 period; rests return 0.
module note_period_rom
  import synth_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  note_t        note,
  output logic [W-1:0] period
);

  always_comb begin
    period = '0;
    case (note)
      4'd1:    period = W'(BASE_PERIOD[0]);
      4'd2:    period = W'(BASE_PERIOD[1]);
      4'd3:    period = W'(BASE_PERIOD[2]);
      4'd4:    period = W'(BASE_PERIOD[3]);
      4'd5:    period = W'(BASE_PERIOD[4]);
      4'd6:    period = W'(BASE_PERIOD[5]);
      4'd7:    period = W'(BASE_PERIOD[6]);
      4'd8:    period = W'(BASE_PERIOD[7]);
      4'd9:    period = W'(BASE_PERIOD[8]);
      4'd10:   period = W'(BASE_PERIOD[9]);
      4'd11:   period = W'(BASE_PERIOD[10]);
      4'd12:   period = W'(BASE_PERIOD[11]);
      default: period = '0;
    endcase
  end

endmodule

// File: rtl/oscillator_counter.sv
// Free-running note phase counter; snapshots phase/period once per sample window
// so the downstream divider can form a sawtooth sample.
module oscillator_counter
  import synth_pkg::*;
#(
  parameter int CNT_W      = synth_pkg::CNT_W,
  parameter int SAMPLE_CYC = synth_pkg::SAMPLE_CYC,
  parameter int OCT_W      = synth_pkg::OCT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  oscillator_counter_if.master bus
);

  localparam int TICK_W = $clog2(SAMPLE_CYC);

  note_t             note_q;
  logic [OCT_W-1:0]  oct_q;
  logic [CNT_W-1:0]  phase;
  logic [TICK_W-1:0] tick;

  logic [CNT_W-1:0]  base;
  logic [CNT_W-1:0]  per;
  logic              active;
  logic              changed;
  logic              tick_last;

  note_period_rom #(.W(CNT_W)) u_rom (
    .note   (note_q),
    .period (base)
  );

  // Period and activity come from the registered note, so a note change on a
  // sample edge still presents the old, self-consistent phase/period pair.
  assign per       = base >> oct_q;
  assign active    = is_active(note_q);
  assign changed   = {bus.note_sel, bus.octave} != {note_q, oct_q};
  assign tick_last = (tick == TICK_W'(SAMPLE_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q            <= NOTE_REST;
      oct_q             <= '0;
      phase             <= '0;
      tick              <= '0;
      bus.divider       <= '1;
      bus.dividend      <= '0;
      bus.en            <= 1'b0;
      bus.sample_strobe <= 1'b0;
    end else begin
      note_q <= bus.note_sel;
      oct_q  <= bus.octave;
      tick   <= tick + TICK_W'(1);

      if (changed) begin
        phase <= '0;
      end else if (active) begin
        phase <= (phase == per - CNT_W'(1)) ? '0 : phase + CNT_W'(1);
      end else begin
        phase <= '0;
      end

      bus.sample_strobe <= tick_last;
      if (tick_last) begin
        if (active) begin
          bus.dividend <= phase;
          bus.divider  <= per;
          bus.en       <= 1'b1;
        end else begin
          bus.dividend <= '0;
          bus.divider  <= '1;
          bus.en       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/oscillator_counter.md
Name: oscillator_counter

Overview:
- Note-pitch phase generator that sits directly upstream of sequential_divider.
- Converts a selected note and octave into a period value (`divider`) and a free-running phase count.
- Snapshots the phase as `dividend` once per 256-cycle sample window, so the divider can form an 8-bit sawtooth sample: quotient ≈ 255·dividend/divider.
- System clock is 10 MHz. Outputs change only at sample boundaries, so the divider sees a stable operand pair for a full window.

Parameters:
- CNT_W, 16, width of the period, phase and output operands.
- SAMPLE_CYC, 256, clock cycles per sample window (power of two).
- OCT_W, 2, width of the octave-shift input.

Ports:
- clk  in  1  system clock, 10 MHz, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- note_sel  in  4  0 = rest; 1..12 = C4..B4; 13..15 = rest.
- octave  in  OCT_W  right-shift applied to the base period (0 = octave 4, 1 = octave 5, ...).
- divider  out  CNT_W  registered period for the downstream divider.
- dividend  out  CNT_W  registered phase snapshot for the downstream divider.
- en  out  1  registered level; high while a valid note pair is being presented.
- sample_strobe  out  1  one-cycle pulse on the cycle the outputs update.

Behaviour:
- Reset (async, any time, including mid-window):
  - divider = 16'hFFFF, dividend = 0, en = 0, sample_strobe = 0.
  - Internal note_q = 0, oct_q = 0, phase = 0, tick = 0.
- Base period ROM (combinational, indexed by note_q): 1:38222, 2:36078, 3:34053, 4:32141, 5:30337, 6:28635, 7:27027, 8:25510, 9:24079, 10:22727, 11:21452, 12:20248.
- Effective period: per = base >> oct_q.
- Input registering: every edge, note_q <= note_sel and oct_q <= octave.
- Restart on change: if {note_sel, octave} != {note_q, oct_q}, then phase <= 0 on that edge. This takes priority over increment.
- Otherwise, when active (note_q in 1..12):
  - phase <= (phase == per-1) ? 0 : phase+1.
  - This guarantees phase < per at all times.
- Rest: phase held at 0.
- tick runs free, 0..SAMPLE_CYC-1, from reset. It wraps silently and is unaffected by note changes.
- Sample edge (tick == SAMPLE_CYC-1 before the edge):
  - sample_strobe <= 1 (0 on all other edges).
  - If active: dividend <= phase, divider <= per, en <= 1.
  - If rest: dividend <= 0, divider <= 16'hFFFF, en <= 0.
- divider, dividend and en never change between strobes. A note change mid-window only affects the internal phase; the outputs update together at the next strobe.
- Latency:
  - First strobe occurs on the 256th rising edge after reset release.
  - A note change appears at the outputs at most 256 cycles later.
- Width rules:
  - All arithmetic is unsigned CNT_W.
  - The shift truncates, e.g. A4 with octave=1 gives 11363.
  - Minimum per is 20248 >> 3 = 2531, never 0.
- Simultaneous note change and sample edge: dividend captures the pre-change phase, and divider captures per computed from the pre-change note_q/oct_q, so the pair stays consistent.

Decomposition:
- Package synth_pkg holds:
  - CNT_W, SAMPLE_CYC, NOTE_REST = 4'd0.
  - typedef note_t (logic [3:0]).
  - The 12-entry base period constant array (shared with future oscillators).
- One sub-module, note_period_rom: combinational lookup note_t -> CNT_W period.
- Counters and output registers live in the top module.

Test Plan:
- Reset values: hold rst=1 across 2 edges, then drop on negedge.
  - Required: divider=FFFF, dividend=0, en=0, strobe=0 throughout.
  - Assert rst mid-window and all outputs clear immediately, without waiting for a clock.
- A4 steady: note_sel=10, octave=0 held through reset release.
  - First strobe at edge 256: divider=22727, dividend=254, en=1.
  - Strobe k: dividend=(254+(k-1)·256) mod 22727.
  - Strobe 89: dividend=55 (wrap check).
- Strobe cadence: sample_strobe is exactly 1 cycle wide with exactly 256 cycles between pulses. Outputs are stable between pulses.
- Octave shift: note_sel=10, octave=1.
  - divider=11363 at the next strobe.
  - dividend < 11363 at every strobe over 100 strobes.
- Rest: note_sel=0 after A4 is running.
  - Next strobe: en=0, dividend=0, divider=FFFF.
  - Reapply 10: the following strobe gives en=1 and divider=22727.
- Mid-window change: switch 10→1 (C4) 100 cycles after a strobe.
  - Outputs are unchanged until the next strobe.
  - Then divider=38222 and dividend=155: phase cleared on the change edge, then 156 further edges with the last one capturing phase before its increment.
